// File: rtl/am2911_ctl_pkg.sv
// Shared constants for the am2911 microprogram control stage: opcodes, microword field
// layout and sequencer source-select codes.
package am2911_ctl_pkg;

  localparam logic [3:0] OP_JZ   = 4'd0;
  localparam logic [3:0] OP_CONT = 4'd1;
  localparam logic [3:0] OP_CJP  = 4'd2;
  localparam logic [3:0] OP_CJS  = 4'd3;
  localparam logic [3:0] OP_CRTN = 4'd4;
  localparam logic [3:0] OP_LDCT = 4'd5;
  localparam logic [3:0] OP_RPCT = 4'd6;
  localparam logic [3:0] OP_LOOP = 4'd7;
  localparam logic [3:0] OP_PUSH = 4'd8;
  localparam logic [3:0] OP_LDAR = 4'd9;

  // Control field {op, csel, cpol} sits above {ba, user}; offsets are relative to its LSB.
  localparam int unsigned OP_W     = 4;
  localparam int unsigned CSEL_W   = 2;
  localparam int unsigned CTL_W    = OP_W + CSEL_W + 1;
  localparam int unsigned CPOL_OFS = 0;
  localparam int unsigned CSEL_OFS = 1;
  localparam int unsigned OP_OFS   = 3;

  localparam logic [1:0] S_UPC = 2'b00;
  localparam logic [1:0] S_AR  = 2'b01;
  localparam logic [1:0] S_STK = 2'b10;
  localparam logic [1:0] S_D   = 2'b11;

endpackage

// File: rtl/am2911_cstore.sv
// Writable control store: asynchronous read, synchronous write, contents not reset.
// A same-cycle write to the read address returns the old word until the edge.
module am2911_cstore #(
  parameter int unsigned AWIDTH = 4,
  parameter int unsigned DWIDTH = 19
) (
  input  logic              cp_i,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] wa_i,
  input  logic [DWIDTH-1:0] wd_i,
  input  logic [AWIDTH-1:0] ra_i,
  output logic [DWIDTH-1:0] rd_o
);

  localparam int unsigned Depth = 2 ** AWIDTH;

  logic [DWIDTH-1:0] mem_q [Depth];

  always_ff @(posedge cp_i) begin
    if (we_i) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  assign rd_o = mem_q[ra_i];

endmodule

// File: rtl/am2911_ctl.sv
// Microprogram control stage around one am2911 slice: control store, pipeline register,
// loop counter and next-address decode. Define AM2911CTL_CCREG_EN to register cc first.
module am2911_ctl
  import am2911_ctl_pkg::*;
#(
  parameter int unsigned AWIDTH = 4,
  parameter int unsigned UWIDTH = 8,
  localparam int unsigned DWIDTH = CTL_W + AWIDTH + UWIDTH
) (
  input  logic              cp_i,
  input  logic              rst_i,
  input  logic [AWIDTH-1:0] y_i,
  input  logic [3:0]        cc_i,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] wa_i,
  input  logic [DWIDTH-1:0] wd_i,
  output logic [AWIDTH-1:0] d_o,
  output logic [1:0]        s_o,
  output logic              fe_n_o,
  output logic              pup_o,
  output logic              zero_n_o,
  output logic              re_n_o,
  output logic              cn_o,
  output logic              oe_n_o,
  output logic [UWIDTH-1:0] uword_o,
  output logic [AWIDTH-1:0] ctr_o,
  output logic              ctz_o
);

  localparam int unsigned BaLsb  = UWIDTH;
  localparam int unsigned CtlLsb = UWIDTH + AWIDTH;

  logic [DWIDTH-1:0] rd_word;
  logic [DWIDTH-1:0] pl_q;
  logic [AWIDTH-1:0] ctr_q, ctr_d;
  logic [3:0]        cc_use;
  logic [3:0]        op;
  logic [1:0]        csel;
  logic              cpol;
  logic [AWIDTH-1:0] ba;
  logic              cond;

  am2911_cstore #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH)
  ) u_cstore (
    .cp_i (cp_i),
    .we_i (we_i),
    .wa_i (wa_i),
    .wd_i (wd_i),
    .ra_i (y_i),
    .rd_o (rd_word)
  );

  // Reset leaves an all-zero word in the pipeline, i.e. JZ.
  always_ff @(posedge cp_i or posedge rst_i) begin
    if (rst_i) begin
      pl_q  <= '0;
      ctr_q <= '0;
    end else begin
      pl_q  <= rd_word;
      ctr_q <= ctr_d;
    end
  end

`ifdef AM2911CTL_CCREG_EN
  logic [3:0] cc_q;

  always_ff @(posedge cp_i or posedge rst_i) begin
    if (rst_i) begin
      cc_q <= '0;
    end else begin
      cc_q <= cc_i;
    end
  end

  assign cc_use = cc_q;
`else
  assign cc_use = cc_i;
`endif

  assign op   = pl_q[CtlLsb + OP_OFS +: OP_W];
  assign csel = pl_q[CtlLsb + CSEL_OFS +: CSEL_W];
  assign cpol = pl_q[CtlLsb + CPOL_OFS];
  assign ba   = pl_q[BaLsb +: AWIDTH];
  assign cond = cc_use[csel] ^ cpol;

  always_comb begin
    s_o      = S_UPC;
    fe_n_o   = 1'b1;
    pup_o    = 1'b0;
    zero_n_o = 1'b1;
    re_n_o   = 1'b1;
    ctr_d    = ctr_q;
    case (op)
      OP_JZ:   zero_n_o = 1'b0;
      OP_CJP:  if (cond) s_o = S_D;
      OP_CJS: begin
        if (cond) begin
          s_o    = S_D;
          fe_n_o = 1'b0;
          pup_o  = 1'b1;
        end
      end
      OP_CRTN: begin
        if (cond) begin
          s_o    = S_STK;
          fe_n_o = 1'b0;
        end
      end
      OP_LDCT: ctr_d = ba;
      // Counter saturates at zero: no branch and no decrement once exhausted.
      OP_RPCT: begin
        if (ctr_q != '0) begin
          s_o   = S_D;
          ctr_d = ctr_q - AWIDTH'(1);
        end
      end
      OP_LOOP: begin
        if (cond) begin
          fe_n_o = 1'b0;
        end else begin
          s_o = S_STK;
        end
      end
      OP_PUSH: begin
        fe_n_o = 1'b0;
        pup_o  = 1'b1;
      end
      OP_LDAR: re_n_o = 1'b0;
      default: ;
    endcase
  end

  assign d_o     = ba;
  assign uword_o = pl_q[UWIDTH-1:0];
  assign cn_o    = 1'b1;
  assign oe_n_o  = 1'b0;
  assign ctr_o   = ctr_q;
  assign ctz_o   = (ctr_q == '0);

endmodule

// File: tb/tb_am2911_ctl.sv
// Self-checking bench for am2911_ctl: directed test-plan sequences plus randomized traffic,
// all compared every cycle against a behavioural model of the microprogram rules.
module tb_am2911_ctl;

  localparam int unsigned AW = 4;
  localparam int unsigned UW = 8;
  localparam int unsigned DW = 7 + AW + UW;

  logic          cp = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] y = '0;
  logic [3:0]    cc = '0;
  logic          we = 1'b0;
  logic [AW-1:0] wa = '0;
  logic [DW-1:0] wd = '0;

  logic [AW-1:0] d, ctr;
  logic [1:0]    s;
  logic          fe_n, pup, zero_n, re_n, cn, oe_n, ctz;
  logic [UW-1:0] uword;

  am2911_ctl #(
    .AWIDTH (AW),
    .UWIDTH (UW)
  ) dut (
    .cp_i     (cp),
    .rst_i    (rst),
    .y_i      (y),
    .cc_i     (cc),
    .we_i     (we),
    .wa_i     (wa),
    .wd_i     (wd),
    .d_o      (d),
    .s_o      (s),
    .fe_n_o   (fe_n),
    .pup_o    (pup),
    .zero_n_o (zero_n),
    .re_n_o   (re_n),
    .cn_o     (cn),
    .oe_n_o   (oe_n),
    .uword_o  (uword),
    .ctr_o    (ctr),
    .ctz_o    (ctz)
  );

  always #5 cp = ~cp;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state: what the store, pipeline, counter and cc register must hold.
  logic [DW-1:0] m_store [16];
  logic [DW-1:0] m_pl  = '0;
  logic [AW-1:0] m_ctr = '0;
  logic [3:0]    m_ccq = '0;

  function automatic logic [DW-1:0] mw(input logic [3:0] op, input logic [1:0] csel,
                                       input logic cpol, input logic [3:0] ba,
                                       input logic [7:0] user);
    return {op, csel, cpol, ba, user};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] cc_src();
`ifdef AM2911CTL_CCREG_EN
    return m_ccq;
`else
    return cc;
`endif
  endfunction

  // Next-address rules for one microword, plus the counter value it leaves behind.
  task automatic model_out(input logic [DW-1:0] w, input logic [AW-1:0] c,
                           input logic [3:0] ccv, output logic [1:0] es, output logic efe,
                           output logic epup, output logic ezero, output logic ere,
                           output logic [AW-1:0] nctr);
    logic [3:0] op;
    logic [1:0] csel;
    logic       cond;
    op   = w[18:15];
    csel = w[14:13];
    cond = ccv[csel] ^ w[12];
    es = 2'd0; efe = 1'b1; epup = 1'b0; ezero = 1'b1; ere = 1'b1; nctr = c;
    case (op)
      4'd0: ezero = 1'b0;
      4'd2: if (cond) es = 2'd3;
      4'd3: if (cond) begin es = 2'd3; efe = 1'b0; epup = 1'b1; end
      4'd4: if (cond) begin es = 2'd2; efe = 1'b0; end
      4'd5: nctr = w[11:8];
      4'd6: if (c != 0) begin es = 2'd3; nctr = c - 1; end
      4'd7: if (cond) efe = 1'b0; else es = 2'd2;
      4'd8: begin efe = 1'b0; epup = 1'b1; end
      4'd9: ere = 1'b0;
      default: ;
    endcase
  endtask

  task automatic check_all();
    logic [1:0]    es;
    logic          efe, epup, ezero, ere;
    logic [AW-1:0] nctr;
    model_out(m_pl, m_ctr, cc_src(), es, efe, epup, ezero, ere, nctr);
    chk("s", 32'(s), 32'(es));
    chk("fe_", 32'(fe_n), 32'(efe));
    chk("pup", 32'(pup), 32'(epup));
    chk("zero_", 32'(zero_n), 32'(ezero));
    chk("re_", 32'(re_n), 32'(ere));
    chk("cn", 32'(cn), 32'd1);
    chk("oe_", 32'(oe_n), 32'd0);
    chk("d", 32'(d), 32'(m_pl[11:8]));
    chk("uword", 32'(uword), 32'(m_pl[7:0]));
    chk("ctr", 32'(ctr), 32'(m_ctr));
    chk("ctz", 32'(ctz), 32'(m_ctr == 0));
  endtask

  always @(negedge cp) begin
    if (chk_en) check_all();
  end

  task automatic model_reset();
    m_pl  = '0;
    m_ctr = '0;
    m_ccq = '0;
  endtask

  // One rising edge: advance the model with the inputs held across it.
  task automatic tick();
    logic [1:0]    es;
    logic          efe, epup, ezero, ere;
    logic [AW-1:0] nctr;
    @(posedge cp);
    if (rst) begin
      model_reset();
    end else begin
      model_out(m_pl, m_ctr, cc_src(), es, efe, epup, ezero, ere, nctr);
      m_pl  = m_store[y];
      m_ctr = nctr;
      m_ccq = cc;
    end
    if (we) m_store[wa] = wd;
    #1;
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] w);
    we = 1'b1; wa = a; wd = w;
    tick();
    we = 1'b0;
  endtask

  initial begin
    logic [7:0] u0;
    int         exp_ctr [4];
    int         exp_s   [4];
    exp_ctr = '{2, 1, 0, 0};
    exp_s   = '{3, 3, 0, 0};

    #1 rst = 1'b1;
    model_reset();
    chk_en = 1'b1;

    // Preload every word with CONT while reset is held.
    for (int i = 0; i < 16; i++) write_word(AW'(i), mw(4'd1, 2'd0, 1'b0, 4'd0, 8'($urandom)));
    u0 = m_store[0][7:0];
    chk("rst_zero_", 32'(zero_n), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_fe_", 32'(fe_n), 32'd1);
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_uword", 32'(uword), 32'd0);
    chk("rst_ctz", 32'(ctz), 32'd1);

    rst = 1'b0; y = '0;
    tick();
    chk("first_zero_", 32'(zero_n), 32'd1);
    chk("first_s", 32'(s), 32'd0);
    chk("first_fe_", 32'(fe_n), 32'd1);
    chk("first_uword", 32'(uword), 32'(u0));

    // CJP on cc[2], taken then not taken.
    write_word(4'd3, mw(4'd2, 2'd2, 1'b0, 4'b1010, 8'h5A));
    y = 4'd3; cc = 4'b0100;
    tick();
    chk("cjp_taken_s", 32'(s), 32'd3);
    chk("cjp_taken_d", 32'(d), 32'hA);
    cc = 4'b0000;
    #1;
`ifdef AM2911CTL_CCREG_EN
    chk("cjp_ccreg_hold_s", 32'(s), 32'd3);
    tick();
    chk("cjp_ccreg_late_s", 32'(s), 32'd0);
`else
    chk("cjp_not_taken_s", 32'(s), 32'd0);
`endif

    // LDCT 3 then RPCT repeated.
    write_word(4'd4, mw(4'd5, 2'd0, 1'b0, 4'd3, 8'h00));
    write_word(4'd6, mw(4'd6, 2'd0, 1'b0, 4'd9, 8'h00));
    y = 4'd4;
    tick();
    y = 4'd6;
    tick();
    chk("rpct0_ctr", 32'(ctr), 32'd3);
    chk("rpct0_s", 32'(s), 32'd3);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rpct_ctr", 32'(ctr), 32'(exp_ctr[k]));
      chk("rpct_s", 32'(s), 32'(exp_s[k]));
    end
    chk("rpct_ctz", 32'(ctz), 32'd1);

    // PUSH, then LOOP not exiting, then LOOP exiting (cond on cc[0]).
    write_word(4'd7, mw(4'd8, 2'd0, 1'b0, 4'd0, 8'h11));
    write_word(4'd8, mw(4'd7, 2'd0, 1'b0, 4'd0, 8'h22));
    y = 4'd7;
    tick();
    chk("push_fe_", 32'(fe_n), 32'd0);
    chk("push_pup", 32'(pup), 32'd1);
    y = 4'd8; cc = 4'b0000;
    tick();
    chk("loop0_s", 32'(s), 32'd2);
    chk("loop0_fe_", 32'(fe_n), 32'd1);
    cc = 4'b0001;
    tick();
    chk("loop1_s", 32'(s), 32'd0);
    chk("loop1_fe_", 32'(fe_n), 32'd0);
    chk("loop1_pup", 32'(pup), 32'd0);

    // Write to the address being read: old word first, new word next time.
    write_word(4'd5, mw(4'd1, 2'd0, 1'b0, 4'd0, 8'hA5));
    y = 4'd5; we = 1'b1; wa = 4'd5; wd = mw(4'd1, 2'd0, 1'b0, 4'd0, 8'h3C);
    tick();
    we = 1'b0;
    chk("coll_old", 32'(uword), 32'hA5);
    tick();
    chk("coll_new", 32'(uword), 32'h3C);

    // Asynchronous reset mid-program with a loaded counter.
    y = 4'd4;
    tick();
    tick();
    chk("pre_rst_ctr", 32'(ctr), 32'd3);
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_zero_", 32'(zero_n), 32'd0);
    chk("async_ctr", 32'(ctr), 32'd0);
    tick();
    rst = 1'b0; y = 4'd5;
    tick();
    chk("retained", 32'(uword), 32'h3C);

    // Randomized traffic, checked every cycle by the compare process.
    for (int n = 0; n < 800; n++) begin
      y  = AW'($urandom);
      cc = 4'($urandom);
      we = ($urandom_range(0, 3) == 0);
      wa = AW'($urandom);
      wd = DW'($urandom);
      if ($urandom_range(0, 63) == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      tick();
    end
    rst = 1'b0;
    we  = 1'b0;
    @(negedge cp);
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
